bcd_scan_display: RTL and testbench
===================================

// Module: bcd_scan_display
// PURPOSE
//  Downstream consumer of the ripple BCD counter chain. Samples NDIG packed BCD digits
//  (asynchronous, ripple-glitchy), synchronises and de-glitches them, and holds a stable
//  display copy. Time-multiplexes that copy onto one 7-segment bus with per-digit enables.
// PARAMETERS
//  NDIG        4     number of BCD digits; digit 0 = bcd_in[3:0] = least significant
//  SCAN_DIV    1000  clk cycles per digit slot (>=2)
//  STABLE_N    3     identical synchronised samples required before capture (>=1)
//  SEG_ACT_LOW 1     1: seg outputs active-low (common anode)
//  AN_ACT_LOW  1     1: an outputs active-low
//  BLANK_LZ    1     1: suppress leading zeros
// PORTS
//  clk     in   1       system clock, rising edge
//  rst     in   1       reset, asynchronous, active-high
//  en      in   1       display enable; 0 = all digits dark, capture continues
//  bcd_in  in   4*NDIG  BCD digits from counter chain, asynchronous to clk
//  seg     out  7       {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  an      out  NDIG    one-hot digit enable, polarity per AN_ACT_LOW
//  upd     out  1       1-cycle pulse when the display copy changes
//  err     out  1       1 while any captured digit > 9
// BEHAVIOUR
//  Reset: seg = all off, an = all off, upd = 0, err = 0. Sync flops, prev, disp_val = 0.
//   cnt, presc, idx = 0.
//  Sync: two flops per bit (s1 -> s2). No other logic runs on bcd_in directly.
//  Filter, each edge:
//   - s2 != prev: prev <= s2, cnt <= 0.
//   - else if cnt == STABLE_N-1: when prev != disp_val, disp_val <= prev and upd <= 1.
//   - else: cnt++.
//   upd = 0 in all other cycles. Clean step held steady: disp_val/upd update on rising
//   edge STABLE_N+3 after the step. A change mid-count restarts cnt, so no capture occurs.
//   Steady input after capture gives no further upd.
//  Scan: presc counts 0..SCAN_DIV-1 and wraps. At wrap, idx advances 0..NDIG-1 -> 0.
//   presc/idx hold while en = 0.
//  Anti-ghost: when presc == SCAN_DIV-1, an = all off. Otherwise an[idx] on (en = 1).
//  Decode (active-high form, inverted if SEG_ACT_LOW):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; 10..15 = 40 (dash).
//  Leading-zero blank: digit i>0 blanked (seg off, an still driven) if BLANK_LZ and
//   disp_val digits i..NDIG-1 are all 0. Digit 0 is never blanked. Invalid codes are
//   never blanked.
//  err = OR over digits of (disp_val digit > 9), registered, updated with disp_val.
//  seg/an registered: output reflects idx/disp_val of the previous edge (1-cycle latency).
//  Async rst mid-scan: immediate return to reset values; scan restarts at idx 0.
// STRUCTURE
//  Package bcd_disp_pkg:
//   - SEG_0..SEG_9, SEG_DASH, SEG_OFF constants (active-high).
//   - function bcd_to_seg(input [3:0]) returning [6:0].
//  Sub-module bcd_stable_capture (sync + filter + disp_val/upd/err), parameterised by
//   width 4*NDIG and STABLE_N. Top holds prescaler, idx, blanking, decode, output regs.
// TESTING (bench: NDIG=4, SCAN_DIV=4, STABLE_N=3, active-low outputs)
//  1. rst pulse mid-scan -> seg = 7F, an = F, upd = 0, err = 0 asynchronously.
//     First an = E (digit 0) after release.
//  2. bcd_in 0000 -> 1234 held -> upd pulses once on edge 6. Scan shows 4,3,2,1:
//     seg = 19,30,24,79, an = E,D,B,7. an = F every 4th cycle.
//  3. bcd_in toggles 1234 <-> 1235 every 2 cycles -> upd never pulses; display stays
//     at the prior value.
//  4. bcd_in 0007 -> digits 1..3 seg = 7F, an still cycles; digit 0 seg = 78.
//     bcd_in 0000 -> digit 0 shows 40.
//  5. bcd_in 00A5 -> err = 1; digit 1 seg = 3F (dash); digit 2/3 blanked.
//     Valid value restores err = 0 on the upd cycle.
//  6. en = 0 for 10 cycles -> an = F, presc/idx frozen; capture of a new value still
//     pulses upd. en = 1 resumes at the same idx.

Source files
------------

// File: rtl/bcd_scan_display_pkg.sv
// rtl/bcd_scan_display_pkg.sv - segment constants and BCD-to-7-segment decode for the scan display
//
// Package bcd_disp_pkg
//   SEG_0..SEG_9, SEG_DASH, SEG_OFF : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   bcd_to_seg(d)                   : decode one BCD digit; codes 10..15 map to a dash

package bcd_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - signal bundle between the counter-chain side and the scan display
//
// Interface bcd_scan_display_if #(NDIG)
//   en      : display enable (0 = all digits dark, capture continues)
//   bcd_in  : 4*NDIG packed BCD digits, asynchronous to the display clock
//   seg     : 7-segment bus {g,f,e,d,c,b,a}, output polarity set by the display
//   an      : one-hot digit enables, output polarity set by the display
//   upd     : 1-cycle pulse when the held display copy changes
//   err     : high while any held digit is above 9
// Modports
//   master  : drives en/bcd_in, observes the display outputs
//   slave   : the display itself

interface bcd_scan_display_if #(
    parameter int NDIG = 4
);

    logic                en;
    logic [4*NDIG-1:0]   bcd_in;
    logic [6:0]          seg;
    logic [NDIG-1:0]     an;
    logic                upd;
    logic                err;

    modport master (
        output en,
        output bcd_in,
        input  seg,
        input  an,
        input  upd,
        input  err
    );

    modport slave (
        input  en,
        input  bcd_in,
        output seg,
        output an,
        output upd,
        output err
    );

endinterface

// File: rtl/bcd_scan_display_capture.sv
// rtl/bcd_scan_display_capture.sv - synchroniser and stability filter producing the held display copy
//
// Module bcd_stable_capture #(W, STABLE_N)
//   clk   in   1  system clock, rising edge
//   rst   in   1  asynchronous, active-high reset
//   din   in   W  packed BCD digits from a ripple counter (glitchy, asynchronous)
//   dout  out  W  held display copy, only changes after STABLE_N identical samples
//   upd   out  1  1-cycle pulse on the edge dout changes
//   err   out  1  high while any 4-bit digit of dout is above 9

module bcd_stable_capture #(
    parameter int W        = 16,
    parameter int STABLE_N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         upd,
    output logic         err
);

    localparam int ND = W / 4;
    localparam int CW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);

    // s1/s2 form a plain two-flop synchroniser; nothing else looks at din,
    // so a ripple in flight can at worst produce one odd sample in s2, which
    // the filter below then refuses to capture.
    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [W-1:0]  prev;
    logic [CW-1:0] cnt;

    function automatic logic any_invalid(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
            cnt  <= '0;
            dout <= '0;
            upd  <= 1'b0;
            err  <= 1'b0;
        end else begin
            s1  <= din;
            s2  <= s1;
            upd <= 1'b0;
            if (s2 != prev) begin
                // Any change restarts the stability window.
                prev <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                // cnt parks here; steady input keeps comparing against dout
                // but only a real difference produces a capture and a pulse.
                if (prev != dout) begin
                    dout <= prev;
                    upd  <= 1'b1;
                    err  <= any_invalid(prev);
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - time-multiplexed 7-segment driver for a ripple BCD counter chain
//
// Module bcd_scan_display #(NDIG, SCAN_DIV, STABLE_N, SEG_ACT_LOW, AN_ACT_LOW, BLANK_LZ)
//   clk   in   1                      system clock, rising edge
//   rst   in   1                      asynchronous, active-high reset
//   bus   bcd_scan_display_if.slave   en, bcd_in in; seg, an, upd, err out
// Digit 0 is bcd_in[3:0], the least significant digit. Each digit owns SCAN_DIV
// clocks; the last clock of every slot drives no anode so the segment bus can
// change without ghosting into the neighbouring digit.

module bcd_scan_display #(
    parameter int NDIG        = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int STABLE_N    = 3,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                rst,
    bcd_scan_display_if.slave   bus
);

    import bcd_disp_pkg::*;

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    // XOR masks converting the internal active-high form to pin polarity.
    localparam logic [6:0]      SEG_INV    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NDIG-1:0] AN_INV     = (AN_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [4*NDIG-1:0] disp_val;
    logic              upd;
    logic              err;

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [6:0]        seg_q;
    logic [NDIG-1:0]   an_q;

    logic [3:0]        cur_digit;
    logic [NDIG-1:0]   an_oh;
    logic              zero_from_idx;
    logic              blank;
    logic              show;
    logic [6:0]        seg_ah;
    logic [NDIG-1:0]   an_ah;

    bcd_stable_capture #(
        .W        (4 * NDIG),
        .STABLE_N (STABLE_N)
    ) u_capture (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.bcd_in),
        .dout (disp_val),
        .upd  (upd),
        .err  (err)
    );

    // Digit select, one-hot anode and leading-zero test for the current slot.
    // zero_from_idx is true when every digit at or above idx is 0; digit 0 is
    // excluded from blanking so a value of zero still shows a single "0".
    // Invalid codes are non-zero, so they are never blanked.
    always_comb begin
        cur_digit     = 4'd0;
        an_oh         = '0;
        zero_from_idx = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (IW'(i) == idx) begin
                cur_digit = disp_val[4*i +: 4];
                an_oh[i]  = 1'b1;
            end
            if ((IW'(i) >= idx) && (disp_val[4*i +: 4] != 4'd0)) begin
                zero_from_idx = 1'b0;
            end
        end
        blank  = (BLANK_LZ != 0) && (idx != '0) && zero_from_idx;
        show   = bus.en && (presc != PRESC_LAST);
        seg_ah = (show && !blank) ? bcd_to_seg(cur_digit) : SEG_OFF;
        an_ah  = show ? an_oh : '0;
    end

    // Prescaler, digit index and registered pin outputs. Outputs are stored
    // already in pin polarity so reset drives them dark immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            seg_q <= SEG_OFF ^ SEG_INV;
            an_q  <= AN_INV;
        end else begin
            if (bus.en) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
            seg_q <= seg_ah ^ SEG_INV;
            an_q  <= an_ah ^ AN_INV;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.upd = upd;
    assign bus.err = err;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed self-checking bench for bcd_scan_display

module tb_bcd_scan_display;

    logic clk;
    logic rst;

    bcd_scan_display_if #(.NDIG(4)) bus ();

    bcd_scan_display #(
        .NDIG        (4),
        .SCAN_DIV    (4),
        .STABLE_N    (3),
        .SEG_ACT_LOW (1),
        .AN_ACT_LOW  (1),
        .BLANK_LZ    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors;
    int         checks;
    int         n_en;      // enabled clock edges since reset release
    logic [3:0] exp_an;    // expected an after the edge just taken
    int         exp_dig;   // digit expected on seg, -1 when dark
    logic [6:0] segs [4];  // expected active-low seg per digit

    // Advance one clock from a falling edge to the next falling edge,
    // computing the expected anode pattern from the scan position.
    task automatic tick();
        logic [3:0] oh;
        int p;
        int d;
        if (bus.en) begin
            p = n_en % 4;
            d = (n_en / 4) % 4;
            oh = 4'b0001 << d;
            exp_an  = (p == 3) ? 4'hF : ~oh;
            exp_dig = (p == 3) ? -1 : d;
            n_en++;
        end else begin
            exp_an  = 4'hF;
            exp_dig = -1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        segs[0] = 7'h40; segs[1] = 7'h7F; segs[2] = 7'h7F; segs[3] = 7'h7F;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (bus.an !== exp_an) begin
                errors++;
                $display("FAIL reset_scan_an cycle %0d: an=%h expected %h", k, bus.an, exp_an);
            end
            if (exp_dig >= 0) begin
                checks++;
                if (bus.seg !== segs[exp_dig]) begin
                    errors++;
                    $display("FAIL reset_scan_seg cycle %0d: seg=%h expected %h", k, bus.seg, segs[exp_dig]);
                end
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.seg !== 7'h7F) begin errors++; $display("FAIL rst_seg: seg=%h expected 7f", bus.seg); end
        checks++;
        if (bus.an !== 4'hF) begin errors++; $display("FAIL rst_an: an=%h expected f", bus.an); end
        checks++;
        if (bus.upd !== 1'b0) begin errors++; $display("FAIL rst_upd: upd=%b expected 0", bus.upd); end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: err=%b expected 0", bus.err); end
        @(negedge clk);
        rst  = 1'b0;
        n_en = 0;
        tick();
        checks++;
        if (bus.an !== 4'hE) begin errors++; $display("FAIL rst_first_an: an=%h expected e", bus.an); end
        checks++;
        if (bus.seg !== 7'h40) begin errors++; $display("FAIL rst_first_seg: seg=%h expected 40", bus.seg); end
    endtask

    task automatic test_capture_scan();
        bus.bcd_in = 16'h1234;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (bus.upd !== (k == 6)) begin
                errors++;
                $display("FAIL cap_upd edge %0d: upd=%b expected %b", k, bus.upd, (k == 6));
            end
        end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL cap_err: err=%b expected 0", bus.err); end
        segs[0] = 7'h19; segs[1] = 7'h30; segs[2] = 7'h24; segs[3] = 7'h79;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (bus.an !== exp_an) begin
                errors++;
                $display("FAIL cap_scan_an cycle %0d: an=%h expected %h", k, bus.an, exp_an);
            end
            if (exp_dig >= 0) begin
                checks++;
                if (bus.seg !== segs[exp_dig]) begin
                    errors++;
                    $display("FAIL cap_scan_seg cycle %0d: seg=%h expected %h", k, bus.seg, segs[exp_dig]);
                end
            end
        end
    endtask

    task automatic test_glitch_reject();
        int pulses;
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            bus.bcd_in = 16'h1235;
            tick(); if (bus.upd === 1'b1) pulses++;
            tick(); if (bus.upd === 1'b1) pulses++;
            bus.bcd_in = 16'h1234;
            tick(); if (bus.upd === 1'b1) pulses++;
            tick(); if (bus.upd === 1'b1) pulses++;
        end
        for (int k = 0; k < 6; k++) begin
            tick(); if (bus.upd === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL glitch_upd: pulses=%0d expected 0", pulses); end
        segs[0] = 7'h19; segs[1] = 7'h30; segs[2] = 7'h24; segs[3] = 7'h79;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (exp_dig >= 0) begin
                checks++;
                if (bus.seg !== segs[exp_dig]) begin
                    errors++;
                    $display("FAIL glitch_seg cycle %0d: seg=%h expected %h", k, bus.seg, segs[exp_dig]);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        bus.bcd_in = 16'h0007;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (bus.upd !== (k == 6)) begin
                errors++;
                $display("FAIL lz7_upd edge %0d: upd=%b expected %b", k, bus.upd, (k == 6));
            end
        end
        segs[0] = 7'h78; segs[1] = 7'h7F; segs[2] = 7'h7F; segs[3] = 7'h7F;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (bus.an !== exp_an) begin
                errors++;
                $display("FAIL lz7_an cycle %0d: an=%h expected %h", k, bus.an, exp_an);
            end
            if (exp_dig >= 0) begin
                checks++;
                if (bus.seg !== segs[exp_dig]) begin
                    errors++;
                    $display("FAIL lz7_seg cycle %0d: seg=%h expected %h", k, bus.seg, segs[exp_dig]);
                end
            end
        end
        bus.bcd_in = 16'h0000;
        for (int k = 0; k < 8; k++) tick();
        segs[0] = 7'h40;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (exp_dig >= 0) begin
                checks++;
                if (bus.seg !== segs[exp_dig]) begin
                    errors++;
                    $display("FAIL lz0_seg cycle %0d: seg=%h expected %h", k, bus.seg, segs[exp_dig]);
                end
            end
        end
    endtask

    task automatic test_invalid();
        bus.bcd_in = 16'h00A5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5 || k == 6) begin
                checks++;
                if (bus.err !== (k == 6)) begin
                    errors++;
                    $display("FAIL inv_err edge %0d: err=%b expected %b", k, bus.err, (k == 6));
                end
            end
        end
        segs[0] = 7'h12; segs[1] = 7'h3F; segs[2] = 7'h7F; segs[3] = 7'h7F;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (exp_dig >= 0) begin
                checks++;
                if (bus.seg !== segs[exp_dig]) begin
                    errors++;
                    $display("FAIL inv_seg cycle %0d: seg=%h expected %h", k, bus.seg, segs[exp_dig]);
                end
            end
        end
        bus.bcd_in = 16'h0042;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) begin
                checks++;
                if (bus.err !== 1'b1) begin errors++; $display("FAIL inv_err_hold: err=%b expected 1", bus.err); end
            end
            if (k == 6) begin
                checks++;
                if (bus.err !== 1'b0) begin errors++; $display("FAIL inv_err_clear: err=%b expected 0", bus.err); end
                checks++;
                if (bus.upd !== 1'b1) begin errors++; $display("FAIL inv_upd: upd=%b expected 1", bus.upd); end
            end
        end
    endtask

    task automatic test_enable();
        bus.en     = 1'b0;
        bus.bcd_in = 16'h0099;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (bus.an !== 4'hF) begin errors++; $display("FAIL en_dark_an cycle %0d: an=%h expected f", k, bus.an); end
            checks++;
            if (bus.upd !== (k == 6)) begin
                errors++;
                $display("FAIL en_upd edge %0d: upd=%b expected %b", k, bus.upd, (k == 6));
            end
        end
        bus.en = 1'b1;
        segs[0] = 7'h10; segs[1] = 7'h10; segs[2] = 7'h7F; segs[3] = 7'h7F;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (bus.an !== exp_an) begin
                errors++;
                $display("FAIL en_resume_an cycle %0d: an=%h expected %h", k, bus.an, exp_an);
            end
            if (exp_dig >= 0) begin
                checks++;
                if (bus.seg !== segs[exp_dig]) begin
                    errors++;
                    $display("FAIL en_resume_seg cycle %0d: seg=%h expected %h", k, bus.seg, segs[exp_dig]);
                end
            end
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        n_en       = 0;
        exp_an     = 4'hF;
        exp_dig    = -1;
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.bcd_in = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.an !== 4'hF) begin errors++; $display("FAIL por_an: an=%h expected f", bus.an); end
        checks++;
        if (bus.seg !== 7'h7F) begin errors++; $display("FAIL por_seg: seg=%h expected 7f", bus.seg); end
        rst = 1'b0;
        test_reset();
        test_capture_scan();
        test_glitch_reject();
        test_leading_zero();
        test_invalid();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
